// File: rtl/ct_f_spsram_req_ctrl_if.sv
// ----------------------------------------------------------------------------
// ct_f_spsram_req_ctrl_if
//   Request/response handshake bundle for ct_f_spsram_req_ctrl.
//
//   Request channel  : req_vld/req_rdy handshake carrying req_wr, req_addr,
//                      req_wdata and req_wmask (per-bit, active-high).
//   Response channel : rsp_vld/rsp_rdy handshake carrying rsp_rdata.
//                      Only reads produce a response.
//
//   Modports
//     master : the initiator that issues requests and consumes responses.
//     slave  : the controller that accepts requests and returns responses.
// ----------------------------------------------------------------------------
interface ct_f_spsram_req_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 144
);

  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_wmask;

  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_vld,
    output req_wr,
    output req_addr,
    output req_wdata,
    output req_wmask,
    output rsp_rdy,
    input  req_rdy,
    input  rsp_vld,
    input  rsp_rdata
  );

  modport slave (
    input  req_vld,
    input  req_wr,
    input  req_addr,
    input  req_wdata,
    input  req_wmask,
    input  rsp_rdy,
    output req_rdy,
    output rsp_vld,
    output rsp_rdata
  );

endinterface

// File: rtl/ct_f_spsram_req_ctrl.sv
// ----------------------------------------------------------------------------
// ct_f_spsram_req_ctrl
//   Initiator-side controller for a single-port SRAM macro with active-low
//   strobes (CEN/GWEN/WEN) and a one-cycle read latency on Q.
//
//   A valid/ready request stream is turned into SRAM strobes in the cycle the
//   request is accepted. Read data returns on Q one cycle later and is
//   captured into a 2-entry response FIFO. New requests are only accepted
//   while the FIFO plus the in-flight read leave room for another response,
//   so the FIFO can never overflow and one read per cycle is sustained when
//   responses are drained every cycle.
//
//   Optional feature (macro CT_SPSRAM_REQ_CTRL_INIT_EN):
//     defined   : after reset the whole array is zero-filled (one write per
//                 cycle, addresses 0..DEPTH-1) before traffic is accepted.
//     undefined : no sweep; the controller runs from the first cycle after
//                 reset and the array contents are left uninitialised.
//
//   Ports
//     CLK        clock, shared with the SRAM macro
//     RST        synchronous active-high reset; while high all outputs show
//                their idle/reset values
//     bus        request/response handshake (slave modport)
//     init_done  array ready for traffic
//     A          SRAM address
//     CEN        SRAM chip enable, active-low
//     GWEN       SRAM global write enable, active-low
//     WEN        SRAM per-bit write enable, active-low
//     D          SRAM write data
//     Q          SRAM read data, valid the cycle after a read access
// ----------------------------------------------------------------------------
module ct_f_spsram_req_ctrl #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 144
) (
  input  logic                  CLK,
  input  logic                  RST,
  ct_f_spsram_req_ctrl_if.slave bus,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

`ifdef CT_SPSRAM_REQ_CTRL_INIT_EN
  typedef enum logic {StInit, StRun} state_e;
  localparam state_e RstState = StInit;
`else
  typedef enum logic {StRun} state_e;
  localparam state_e RstState = StRun;
`endif

  state_e state_q, state_d;

  // Response FIFO: two entries addressed by 1-bit pointers.
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            cnt_q;

  // A read was issued last cycle; its data is on Q this cycle.
  logic                  rd_pend_q;

  logic                  run;
  logic                  accept;
  logic                  rd_accept;
  logic                  push;
  logic                  pop;
  logic [2:0]            credit_used;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RstState;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef CT_SPSRAM_REQ_CTRL_INIT_EN
  // --------------------------------------------------------------------------
  // Zero-fill sweep: one write per cycle, addresses 0..DEPTH-1
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_active;

  always_ff @(posedge CLK) begin
    if (RST) begin
      init_cnt_q <= '0;
    end else begin
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_active = 1'b0;
    unique case (state_q)
      StInit: begin
        init_active = 1'b1;
        init_cnt_d  = init_cnt_q + 1'b1;
        if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        state_d = StRun;
      end
    endcase
  end
`else
  assign state_d = StRun;
`endif

  // --------------------------------------------------------------------------
  // Request acceptance and credit rule
  // --------------------------------------------------------------------------
  // Outputs are held at their idle values while RST is high, whatever state
  // the register still holds in that cycle.
  assign run       = (state_q == StRun) && !RST;
  assign init_done = run;

  assign pop  = bus.rsp_vld && bus.rsp_rdy;
  assign push = rd_pend_q;

  // Responses already owned (queued or on Q) after this cycle's pop. pop only
  // fires with a non-empty FIFO, so this cannot underflow.
  assign credit_used = {1'b0, cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};

  assign bus.req_rdy = run && (credit_used < 3'd2);
  assign accept      = bus.req_vld && bus.req_rdy;
  assign rd_accept   = accept && !bus.req_wr;

  // --------------------------------------------------------------------------
  // SRAM strobes (combinational in the accept cycle)
  // --------------------------------------------------------------------------
  always_comb begin
    CEN  = 1'b1;
    GWEN = 1'b1;
    WEN  = '1;
    A    = bus.req_addr;
    D    = bus.req_wdata;
    if (accept) begin
      CEN  = 1'b0;
      GWEN = ~bus.req_wr;
      WEN  = bus.req_wr ? ~bus.req_wmask : '1;
    end
`ifdef CT_SPSRAM_REQ_CTRL_INIT_EN
    else if (init_active && !RST) begin
      CEN  = 1'b0;
      GWEN = 1'b0;
      WEN  = '0;
      A    = init_cnt_q;
      D    = '0;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // Read pipeline and response FIFO control
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_pend_q <= 1'b0;
      cnt_q     <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
    end else begin
      rd_pend_q <= rd_accept;
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // FIFO storage needs no reset: an empty FIFO presents zero on rsp_rdata.
  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      fifo_q[wr_ptr_q] <= Q;
    end
  end

  assign bus.rsp_vld   = !RST && (cnt_q != 2'd0);
  assign bus.rsp_rdata = bus.rsp_vld ? fifo_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_ct_f_spsram_req_ctrl.sv
module tb_ct_f_spsram_req_ctrl;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 144;
  localparam int unsigned DEPTH = 16;

  localparam logic [DW-1:0] ONES  = {DW{1'b1}};
  localparam logic [DW-1:0] JUNK  = {9{16'hDEAD}};
  localparam logic [DW-1:0] PAT_A = {9{16'hA5A5}};
  localparam logic [DW-1:0] PAT_M = {{8{16'hA5A5}}, 16'hA5FF};
  localparam logic [DW-1:0] MASK8 = {{136{1'b0}}, 8'hFF};
  localparam logic [DW-1:0] WEN8  = {{136{1'b1}}, 8'h00};
  localparam logic [DW-1:0] D1    = {{128{1'b0}}, 16'h1111};
  localparam logic [DW-1:0] D2    = {{128{1'b0}}, 16'h2222};

`ifdef CT_SPSRAM_REQ_CTRL_INIT_EN
  localparam int            INIT_CYCLES = 16;
  localparam logic [DW-1:0] FILL        = '0;
`else
  localparam int            INIT_CYCLES = 0;
  localparam logic [DW-1:0] FILL        = JUNK;
`endif

  logic          CLK;
  logic          RST;
  logic          init_done;
  logic [AW-1:0] A;
  logic          CEN;
  logic          GWEN;
  logic [DW-1:0] WEN;
  logic [DW-1:0] D;
  logic [DW-1:0] sram_q;

  ct_f_spsram_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ct_f_spsram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .init_done (init_done),
    .A         (A),
    .CEN       (CEN),
    .GWEN      (GWEN),
    .WEN       (WEN),
    .D         (D),
    .Q         (sram_q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // Behavioural SRAM macro: bit-masked write, registered read.
  logic [DW-1:0] sram_mem [DEPTH];
  bit            sram_primed = 1'b0;
  always @(posedge CLK) begin
    if (!sram_primed) begin
      for (int i = 0; i < DEPTH; i++) sram_mem[i] <= JUNK;
      sram_primed <= 1'b1;
    end else if (!CEN) begin
      if (!GWEN) sram_mem[A] <= (sram_mem[A] & WEN) | (D & ~WEN);
      else       sram_q <= sram_mem[A];
    end
  end

  // Response log for directed checks.
  logic [DW-1:0] log_data [$];
  int            log_cyc  [$];
  always @(negedge CLK) begin
    if (bus.rsp_vld && bus.rsp_rdy) begin
      log_data.push_back(bus.rsp_rdata);
      log_cyc.push_back(cyc);
    end
  end

  // --------------------------------------------------------------------------
  // Reference model and per-cycle comparison
  // --------------------------------------------------------------------------
  logic [DW-1:0] mdl_mem [DEPTH];
  bit            mdl_primed = 1'b0;
  int            init_left  = 0;
  logic [DW-1:0] q_data [$];
  int            q_due  [$];
  int            dut_out = 0;

  always @(negedge CLK) begin
    logic          e_rdy, e_vld, e_cen, e_gwen, e_done, e_acc, e_pop;
    logic [DW-1:0] e_rdata, e_wen, e_d;
    logic [AW-1:0] e_a;
    if (!mdl_primed) begin
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = JUNK;
      mdl_primed = 1'b1;
    end
    e_rdy = 1'b0; e_vld = 1'b0; e_cen = 1'b1; e_gwen = 1'b1; e_done = 1'b0;
    e_acc = 1'b0; e_pop = 1'b0; e_rdata = '0; e_wen = ONES; e_d = '0; e_a = '0;
    if (RST) begin
      // idle values only
    end else if (init_left > 0) begin
      e_cen = 1'b0; e_gwen = 1'b0; e_wen = '0; e_d = '0;
      e_a   = AW'(DEPTH - init_left);
    end else begin
      e_done = 1'b1;
      e_vld  = (q_data.size() > 0) && (q_due[0] <= cyc);
      e_rdata = e_vld ? q_data[0] : '0;
      e_pop  = e_vld && bus.rsp_rdy;
      // At most two reads may be owed to the requester at any time.
      e_rdy  = (q_data.size() - int'(e_pop)) < 2;
      e_acc  = bus.req_vld && e_rdy;
      if (e_acc) begin
        e_cen  = 1'b0;
        e_gwen = ~bus.req_wr;
        e_wen  = bus.req_wr ? ~bus.req_wmask : ONES;
        e_a    = bus.req_addr;
        e_d    = bus.req_wdata;
      end
    end

    check("req_rdy",   DW'(bus.req_rdy), DW'(e_rdy));
    check("rsp_vld",   DW'(bus.rsp_vld), DW'(e_vld));
    check("rsp_rdata", bus.rsp_rdata,    e_rdata);
    check("init_done", DW'(init_done),   DW'(e_done));
    check("CEN",       DW'(CEN),         DW'(e_cen));
    check("GWEN",      DW'(GWEN),        DW'(e_gwen));
    check("WEN",       WEN,              e_wen);
    if (!e_cen)  check("A", DW'(A), DW'(e_a));
    if (!e_cen && !e_gwen) check("D", D, e_d);

    if (RST) begin
      dut_out = 0;
    end else begin
      dut_out += int'(bus.req_vld && bus.req_rdy && !bus.req_wr);
      dut_out -= int'(bus.rsp_vld && bus.rsp_rdy);
      check("no_overflow", DW'(dut_out <= 2), DW'(1'b1));
    end

    // Advance the model across the coming edge.
    if (RST) begin
      q_data.delete();
      q_due.delete();
      init_left = INIT_CYCLES;
    end else if (init_left > 0) begin
      mdl_mem[DEPTH - init_left] = '0;
      init_left--;
    end else begin
      if (e_pop) begin
        q_data.delete(0);
        q_due.delete(0);
      end
      if (e_acc) begin
        if (bus.req_wr) begin
          mdl_mem[bus.req_addr] = (mdl_mem[bus.req_addr] & ~bus.req_wmask) |
                                  (bus.req_wdata & bus.req_wmask);
        end else begin
          q_data.push_back(mdl_mem[bus.req_addr]);
          q_due.push_back(cyc + 2);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_accept(input string name, output int t_acc);
    bit ok = 1'b0;
    t_acc = -1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK);
      if (bus.req_rdy) begin
        ok    = 1'b1;
        t_acc = cyc;
      end
    end
    check(name, DW'(ok), DW'(1'b1));
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [DW-1:0] mask, input logic [DW-1:0] exp_wen);
    int t;
    bus.req_vld = 1'b1; bus.req_wr = 1'b1; bus.req_addr = addr;
    bus.req_wdata = data; bus.req_wmask = mask;
    wait_accept("wr_accept", t);
    check("wr_wen_lit", WEN, exp_wen);
    tick();
    bus.req_vld = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [AW-1:0] addr,
                         input logic [DW-1:0] exp);
    int  t_acc;
    int  t_rsp = -1;
    logic [DW-1:0] got = '0;
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = addr;
    wait_accept("rd_accept", t_acc);
    tick();
    bus.req_vld = 1'b0;
    for (int i = 0; i < 20 && t_rsp < 0; i++) begin
      @(negedge CLK);
      if (bus.rsp_vld) begin
        t_rsp = cyc;
        got   = bus.rsp_rdata;
      end
    end
    check({name, "_lat"}, DW'(t_rsp - t_acc), DW'(2));
    check({name, "_data"}, got, exp);
    tick();
  endtask

  initial begin
    int n, t0, start;
    logic [DW-1:0] exp_seq [3];
    logic [AW-1:0] stream_addr [8];
    logic [DW-1:0] stream_exp  [8];

    RST = 1'b1;
    bus.req_vld = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_wmask = '0; bus.rsp_rdy = 1'b1;
    repeat (3) tick();
    RST = 1'b0;

    // 1: init sweep length, first address, then zero-filled read
    n = 0;
    @(negedge CLK);
`ifdef CT_SPSRAM_REQ_CTRL_INIT_EN
    check("init_first_a",   DW'(A),   DW'(0));
    check("init_first_cen", DW'(CEN), DW'(0));
`endif
    while (!init_done && n < 100) begin
      n++;
      @(negedge CLK);
    end
    check("init_len", DW'(n), DW'(INIT_CYCLES));
    tick();
    do_read("rd7", 4'd7, FILL);

    // 2: full write then read
    do_write(4'd3, PAT_A, ONES, '0);
    do_read("rd3_full", 4'd3, PAT_A);

    // 3: masked write
    do_write(4'd3, ONES, MASK8, WEN8);
    do_read("rd3_mask", 4'd3, PAT_M);

    do_write(4'd1, D1, ONES, '0);
    do_write(4'd2, D2, ONES, '0);

    // 4: back-pressure
    start = log_data.size();
    bus.rsp_rdy = 1'b0;
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 4'd1;
    @(negedge CLK); check("bp_rdy1", DW'(bus.req_rdy), DW'(1));
    tick(); bus.req_addr = 4'd2;
    @(negedge CLK); check("bp_rdy2", DW'(bus.req_rdy), DW'(1));
    tick(); bus.req_addr = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("bp_rdy_low", DW'(bus.req_rdy), DW'(0));
      check("bp_head",    bus.rsp_rdata,    D1);
      tick();
    end
    bus.rsp_rdy = 1'b1;
    @(negedge CLK); check("bp_third_acc", DW'(bus.req_rdy), DW'(1));
    tick(); bus.req_vld = 1'b0;
    repeat (5) tick();
    exp_seq[0] = D1; exp_seq[1] = D2; exp_seq[2] = PAT_M;
    check("bp_count", DW'(log_data.size() - start), DW'(3));
    for (int i = 0; i < 3; i++) begin
      if (start + i < log_data.size()) check("bp_order", log_data[start + i], exp_seq[i]);
    end

    // 5: streaming reads
    start = log_data.size();
    t0 = 0;
    for (int i = 0; i < 8; i++) begin
      stream_addr[i] = AW'((i % 3) + 1);
      stream_exp[i]  = exp_seq[i % 3];
    end
    for (int i = 0; i < 8; i++) begin
      bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = stream_addr[i];
      @(negedge CLK);
      check("stream_rdy", DW'(bus.req_rdy), DW'(1));
      if (i == 0) t0 = cyc;
      tick();
    end
    bus.req_vld = 1'b0;
    repeat (4) tick();
    check("stream_count", DW'(log_data.size() - start), DW'(8));
    for (int i = 0; i < 8; i++) begin
      if (start + i < log_data.size()) begin
        check("stream_data", log_data[start + i], stream_exp[i]);
        check("stream_cyc",  DW'(log_cyc[start + i]), DW'(t0 + 2 + i));
      end
    end

    // 6: reset the cycle after a read accept
    start = log_data.size();
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 4'd1;
    wait_accept("rst_rd_accept", t0);
    tick();
    bus.req_vld = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check("rst_cen",  DW'(CEN),         DW'(1));
    check("rst_vld",  DW'(bus.rsp_vld), DW'(0));
    tick();
    RST = 1'b0;
    @(negedge CLK);
`ifdef CT_SPSRAM_REQ_CTRL_INIT_EN
    check("rst_init_a",   DW'(A),   DW'(0));
    check("rst_init_cen", DW'(CEN), DW'(0));
`endif
    n = 0;
    while (!init_done && n < 100) begin
      n++;
      @(negedge CLK);
    end
    check("rst_init_len", DW'(n), DW'(INIT_CYCLES));
    tick();
    check("rst_no_rsp", DW'(log_data.size() - start), DW'(0));
`ifdef CT_SPSRAM_REQ_CTRL_INIT_EN
    do_read("rd1_after_rst", 4'd1, '0);
`else
    do_read("rd1_after_rst", 4'd1, D1);
`endif
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
